hazard_scoreboard_ctrl: RTL and testbench



---
 rtl/hazard_pkg.sv | 21 ++
 rtl/hz_tag_match.sv | 27 ++
 rtl/hazard_scoreboard_ctrl.sv | 111 +++++++++++
 tb/tb_hazard_scoreboard_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the ID/EX hazard scoreboard: destination tags and action encoding.
// Pure declarations, no logic, no latency.
// No flow control involved.
package hazard_pkg;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
    } tag_t;

    localparam logic [4:0] REG_X0   = 5'd0;
    localparam tag_t       TAG_NONE = '{valid: 1'b0, rd: 5'd0};

    typedef enum logic [1:0] {
        ACT_FREEZE,
        ACT_REDIRECT,
        ACT_STALL,
        ACT_RUN
    } act_t;

endpackage

// File: rtl/hz_tag_match.sv
// Compares one ID source register against the EX/MEM/WB destination tags.
// Purely combinational, zero latency.
// No flow control; the WB tag is ignored when the register file bypasses on write.
module hz_tag_match
    import hazard_pkg::*;
#(
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic [4:0] src_addr,
    input  logic       src_used,
    input  tag_t       tag_EX,
    input  tag_t       tag_MEM,
    input  tag_t       tag_WB,
    output logic       hit
);

    logic hit_ex;
    logic hit_mem;
    logic hit_wb;

    assign hit_ex  = tag_EX.valid  && (tag_EX.rd  == src_addr);
    assign hit_mem = tag_MEM.valid && (tag_MEM.rd == src_addr);
    assign hit_wb  = !WB_BYPASS && tag_WB.valid && (tag_WB.rd == src_addr);

    assign hit = src_used && (src_addr != REG_X0) && (hit_ex || hit_mem || hit_wb);

endmodule

// File: rtl/hazard_scoreboard_ctrl.sv
// RAW-hazard scoreboard and redirect control for the ID/EX register of a no-forwarding 5-stage pipe.
// Outputs are combinational from the current tags; tags and counters update on the falling clock edge.
// Stalls hold PC and IF/ID and inject an ID/EX bubble; en_HZ=0 freezes everything.
module hazard_scoreboard_ctrl
    import hazard_pkg::*;
#(
    parameter bit WB_BYPASS = 1'b1,
    parameter int CNT_W     = 32
) (
    input  logic             clk_HZ,
    input  logic             rst_HZ,
    input  logic             en_HZ,
    input  logic [4:0]       Rs1_addr_ID,
    input  logic [4:0]       Rs2_addr_ID,
    input  logic             Rs1_used_ID,
    input  logic             Rs2_used_ID,
    input  logic [4:0]       Rd_addr_ID,
    input  logic             RegWrite_ID,
    input  logic             Redirect_EX,
    output logic             en_PC_HZ,
    output logic             en_IFID_HZ,
    output logic             flush_IFID_HZ,
    output logic             flush_IDEX_HZ,
    output logic [CNT_W-1:0] stall_cnt_HZ,
    output logic [CNT_W-1:0] flush_cnt_HZ
);

    tag_t tag_EX;
    tag_t tag_MEM;
    tag_t tag_WB;
    tag_t tag_EX_nxt;
    logic hz1;
    logic hz2;
    logic hazard;
    act_t act;

    hz_tag_match #(.WB_BYPASS(WB_BYPASS)) u_match_rs1 (
        .src_addr (Rs1_addr_ID),
        .src_used (Rs1_used_ID),
        .tag_EX   (tag_EX),
        .tag_MEM  (tag_MEM),
        .tag_WB   (tag_WB),
        .hit      (hz1)
    );

    hz_tag_match #(.WB_BYPASS(WB_BYPASS)) u_match_rs2 (
        .src_addr (Rs2_addr_ID),
        .src_used (Rs2_used_ID),
        .tag_EX   (tag_EX),
        .tag_MEM  (tag_MEM),
        .tag_WB   (tag_WB),
        .hit      (hz2)
    );

    assign hazard = hz1 || hz2;

    // Reset drives the same all-quiet outputs as a freeze.
    always_comb begin
        act           = ACT_RUN;
        en_PC_HZ      = 1'b0;
        en_IFID_HZ    = 1'b0;
        flush_IFID_HZ = 1'b0;
        flush_IDEX_HZ = 1'b0;
        tag_EX_nxt    = TAG_NONE;
        if (rst_HZ || !en_HZ) begin
            act = ACT_FREEZE;
        end else if (Redirect_EX) begin
            act = ACT_REDIRECT;
        end else if (hazard) begin
            act = ACT_STALL;
        end
        case (act)
            ACT_REDIRECT: begin
                en_PC_HZ      = 1'b1;
                en_IFID_HZ    = 1'b1;
                flush_IFID_HZ = 1'b1;
                flush_IDEX_HZ = 1'b1;
            end
            ACT_STALL: begin
                flush_IDEX_HZ = 1'b1;
            end
            ACT_RUN: begin
                en_PC_HZ   = 1'b1;
                en_IFID_HZ = 1'b1;
                tag_EX_nxt = '{valid: RegWrite_ID && (Rd_addr_ID != REG_X0), rd: Rd_addr_ID};
            end
            default: ;
        endcase
    end

    always_ff @(negedge clk_HZ) begin
        if (rst_HZ) begin
            tag_EX       <= TAG_NONE;
            tag_MEM      <= TAG_NONE;
            tag_WB       <= TAG_NONE;
            stall_cnt_HZ <= '0;
            flush_cnt_HZ <= '0;
        end else if (en_HZ) begin
            tag_WB  <= tag_MEM;
            tag_MEM <= tag_EX;
            tag_EX  <= tag_EX_nxt;
            if (act == ACT_STALL) begin
                stall_cnt_HZ <= stall_cnt_HZ + CNT_W'(1);
            end
            if (act == ACT_REDIRECT) begin
                flush_cnt_HZ <= flush_cnt_HZ + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// Drives two scoreboards (WB bypass on and off) with directed and random ID traffic.
// Expected outputs come from an in-flight-writer model kept per variant.
module tb_hazard_scoreboard_ctrl;

    logic        clk_HZ = 1'b1;
    logic        rst_HZ = 1'b1;
    logic        en_HZ  = 1'b1;
    logic [4:0]  Rs1_addr_ID = '0;
    logic [4:0]  Rs2_addr_ID = '0;
    logic        Rs1_used_ID = 1'b0;
    logic        Rs2_used_ID = 1'b0;
    logic [4:0]  Rd_addr_ID  = '0;
    logic        RegWrite_ID = 1'b0;
    logic        Redirect_EX = 1'b0;

    logic [3:0]  outs [2];
    logic [31:0] scnt [2];
    logic [31:0] fcnt [2];

    int n_checks = 0;
    int n_fail   = 0;

    // Model: rd of the writer in EX/MEM/WB, 0 meaning none; v=0 bypass, v=1 no bypass.
    int          m_rd [2][3];
    int unsigned m_stall [2];
    int unsigned m_flush [2];

    always #5 clk_HZ = ~clk_HZ;

    hazard_scoreboard_ctrl #(.WB_BYPASS(1'b1), .CNT_W(32)) u_dut_byp (
        .clk_HZ(clk_HZ), .rst_HZ(rst_HZ), .en_HZ(en_HZ),
        .Rs1_addr_ID(Rs1_addr_ID), .Rs2_addr_ID(Rs2_addr_ID),
        .Rs1_used_ID(Rs1_used_ID), .Rs2_used_ID(Rs2_used_ID),
        .Rd_addr_ID(Rd_addr_ID), .RegWrite_ID(RegWrite_ID), .Redirect_EX(Redirect_EX),
        .en_PC_HZ(outs[0][3]), .en_IFID_HZ(outs[0][2]),
        .flush_IFID_HZ(outs[0][1]), .flush_IDEX_HZ(outs[0][0]),
        .stall_cnt_HZ(scnt[0]), .flush_cnt_HZ(fcnt[0])
    );

    hazard_scoreboard_ctrl #(.WB_BYPASS(1'b0), .CNT_W(32)) u_dut_nobyp (
        .clk_HZ(clk_HZ), .rst_HZ(rst_HZ), .en_HZ(en_HZ),
        .Rs1_addr_ID(Rs1_addr_ID), .Rs2_addr_ID(Rs2_addr_ID),
        .Rs1_used_ID(Rs1_used_ID), .Rs2_used_ID(Rs2_used_ID),
        .Rd_addr_ID(Rd_addr_ID), .RegWrite_ID(RegWrite_ID), .Redirect_EX(Redirect_EX),
        .en_PC_HZ(outs[1][3]), .en_IFID_HZ(outs[1][2]),
        .flush_IFID_HZ(outs[1][1]), .flush_IDEX_HZ(outs[1][0]),
        .stall_cnt_HZ(scnt[1]), .flush_cnt_HZ(fcnt[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_src_hit(int v, bit used, int rs);
        int depth;
        depth = (v == 0) ? 2 : 3;
        if (!used || rs == 0) return 1'b0;
        for (int s = 0; s < depth; s++) begin
            if (m_rd[v][s] == rs) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit m_hazard(int v);
        return m_src_hit(v, Rs1_used_ID, int'(Rs1_addr_ID)) ||
               m_src_hit(v, Rs2_used_ID, int'(Rs2_addr_ID));
    endfunction

    function automatic logic [3:0] m_outs(int v);
        if (rst_HZ || !en_HZ) return 4'b0000;
        if (Redirect_EX)      return 4'b1111;
        if (m_hazard(v))      return 4'b0001;
        return 4'b1100;
    endfunction

    task automatic m_reset();
        for (int v = 0; v < 2; v++) begin
            for (int s = 0; s < 3; s++) m_rd[v][s] = 0;
            m_stall[v] = 0;
            m_flush[v] = 0;
        end
    endtask

    task automatic m_advance();
        bit hz;
        if (rst_HZ) begin
            m_reset();
            return;
        end
        if (!en_HZ) return;
        for (int v = 0; v < 2; v++) begin
            hz = m_hazard(v);
            m_rd[v][2] = m_rd[v][1];
            m_rd[v][1] = m_rd[v][0];
            if (Redirect_EX || hz)    m_rd[v][0] = 0;
            else if (RegWrite_ID)     m_rd[v][0] = int'(Rd_addr_ID);
            else                      m_rd[v][0] = 0;
            if (Redirect_EX)          m_flush[v]++;
            else if (hz)              m_stall[v]++;
        end
    endtask

    // One cycle: drive after the rising edge, check mid-phase, then the falling edge commits.
    task automatic step(input bit rst, input bit en, input bit redir,
                        input bit r1u, input logic [4:0] r1,
                        input bit r2u, input logic [4:0] r2,
                        input bit rw, input logic [4:0] rd);
        @(posedge clk_HZ);
        rst_HZ = rst; en_HZ = en; Redirect_EX = redir;
        Rs1_used_ID = r1u; Rs1_addr_ID = r1;
        Rs2_used_ID = r2u; Rs2_addr_ID = r2;
        RegWrite_ID = rw; Rd_addr_ID = rd;
        #1;
        chk("outs_byp",    32'(outs[0]), 32'(m_outs(0)));
        chk("outs_nobyp",  32'(outs[1]), 32'(m_outs(1)));
        chk("stall_byp",   scnt[0], m_stall[0]);
        chk("stall_nobyp", scnt[1], m_stall[1]);
        chk("flush_byp",   fcnt[0], m_flush[0]);
        chk("flush_nobyp", fcnt[1], m_flush[1]);
        m_advance();
    endtask

    task automatic do_reset();
        step(1, 1, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
    endtask

    initial begin
        m_reset();

        // Reset state and a reader with nothing in flight.
        do_reset();
        step(0, 1, 0, 1, 5'd5, 0, 5'd0, 0, 5'd0);
        chk("t1_run_outs", 32'(outs[0]), 32'h0000000c);
        chk("t1_stall", scnt[0], 32'd0);

        // Back-to-back dependence: 2 bubbles with bypass, 3 without.
        do_reset();
        step(0, 1, 0, 0, 5'd0, 0, 5'd0, 1, 5'd5);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 1, 5'd5, 0, 5'd0, 0, 5'd0);
        chk("t2_stall_byp",   scnt[0], 32'd2);
        chk("t3_stall_nobyp", scnt[1], 32'd3);

        // Distance-2 dependence on rs2.
        do_reset();
        step(0, 1, 0, 0, 5'd0, 0, 5'd0, 1, 5'd7);
        step(0, 1, 0, 0, 5'd0, 0, 5'd0, 1, 5'd3);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 5'd0, 1, 5'd7, 0, 5'd0);
        chk("d2_stall_byp",   scnt[0], 32'd1);
        chk("d2_stall_nobyp", scnt[1], 32'd2);

        // x0 as destination and source never stalls.
        do_reset();
        step(0, 1, 0, 0, 5'd0, 0, 5'd0, 1, 5'd0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 5'd0, 1, 5'd0, 0, 5'd0);
        chk("t4_x0_stall", scnt[1], 32'd0);

        // Redirect beats a pending hazard.
        do_reset();
        step(0, 1, 0, 0, 5'd0, 0, 5'd0, 1, 5'd5);
        step(0, 1, 1, 1, 5'd5, 0, 5'd0, 1, 5'd9);
        step(0, 1, 0, 1, 5'd9, 0, 5'd0, 0, 5'd0);
        chk("t5_ex_cleared", 32'(outs[0]), 32'h0000000c);
        chk("t5_flush", fcnt[0], 32'd1);
        chk("t5_stall", scnt[0], 32'd0);

        // Freeze mid-stall, then reset during the remaining stall.
        do_reset();
        step(0, 1, 0, 0, 5'd0, 0, 5'd0, 1, 5'd5);
        step(0, 1, 0, 1, 5'd5, 0, 5'd0, 0, 5'd0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 5'd5, 0, 5'd0, 0, 5'd0);
        chk("t6_frozen_stall", scnt[1], 32'd1);
        step(0, 1, 0, 1, 5'd5, 0, 5'd0, 0, 5'd0);
        step(1, 1, 0, 1, 5'd5, 0, 5'd0, 0, 5'd0);
        step(0, 1, 0, 1, 5'd5, 0, 5'd0, 0, 5'd0);
        chk("t6_after_rst_outs", 32'(outs[1]), 32'h0000000c);
        chk("t6_after_rst_cnt",  scnt[1], 32'd0);

        // Random traffic on a small register window to provoke hazards.
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(99) < 2,
                 $urandom_range(99) < 88,
                 $urandom_range(99) < 10,
                 1'($urandom), 5'($urandom_range(7)),
                 1'($urandom), 5'($urandom_range(7)),
                 $urandom_range(99) < 70, 5'($urandom_range(7)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
